// File: rtl/axi4_m_wburst.sv
// axi4_m_wburst
// AXI4 write master for the QEMU PCIe bridge. Accepts burst commands and a
// separate beat stream, issues INCR bursts of up to 256 beats on independent
// AW and W channels with up to MAX_OUTS writes outstanding, and returns each
// B response on a registered response port.
//
// Ports
//   i_clk, i_rst              clock, asynchronous active-high reset
//   req_addr/len/size         burst command (start address, beats-1, size)
//   req_valid/req_ready       command handshake
//   dat_data/strb             write beat payload
//   dat_valid/dat_ready       beat handshake
//   rsp_valid/resp/ready      registered BRESP of each completed burst
//   err_4k                    one-cycle flag: accepted burst crosses 4KB
//   o_m_aw*/i_m_awready       AXI4 AW channel
//   o_m_w*/i_m_wready         AXI4 W channel (no WID)
//   i_m_b*/o_m_bready         AXI4 B channel (BID ignored)
module axi4_m_wburst #(
    parameter int unsigned TAGW     = 3,
    parameter int unsigned ADRW     = 32,
    parameter int unsigned DATW     = 256,
    parameter int unsigned STBW     = DATW / 8,
    parameter int unsigned MAX_OUTS = 4,
    parameter int unsigned AWID     = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,

    input  logic [ADRW-1:0] req_addr,
    input  logic [7:0]      req_len,
    input  logic [2:0]      req_size,
    input  logic            req_valid,
    output logic            req_ready,

    input  logic [DATW-1:0] dat_data,
    input  logic [STBW-1:0] dat_strb,
    input  logic            dat_valid,
    output logic            dat_ready,

    output logic            rsp_valid,
    output logic [1:0]      rsp_resp,
    input  logic            rsp_ready,

    output logic            err_4k,

    output logic [TAGW-1:0] o_m_awid,
    output logic [ADRW-1:0] o_m_awaddr,
    output logic [7:0]      o_m_awlen,
    output logic [2:0]      o_m_awsize,
    output logic [1:0]      o_m_awburst,
    output logic            o_m_awlock,
    output logic [3:0]      o_m_awcache,
    output logic [2:0]      o_m_awprot,
    output logic [3:0]      o_m_awregion,
    output logic            o_m_awvalid,
    input  logic            i_m_awready,

    output logic [DATW-1:0] o_m_wdata,
    output logic [STBW-1:0] o_m_wstrb,
    output logic            o_m_wlast,
    output logic            o_m_wvalid,
    input  logic            i_m_wready,

    input  logic [TAGW-1:0] i_m_bid,
    input  logic [1:0]      i_m_bresp,
    input  logic            i_m_bvalid,
    output logic            o_m_bready
);

    localparam logic [2:0]  SZ_MAX = 3'($clog2(STBW));
    localparam int unsigned OCW    = $clog2(MAX_OUTS + 1);
    localparam int unsigned PW     = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;

    typedef enum logic {
        W_IDLE,
        W_BURST
    } w_state_t;

    w_state_t         w_state;
    w_state_t         w_state_nxt;

    logic             accept;
    logic             b_hs;
    logic [2:0]       req_size_c;
    logic [16:0]      span_end;

    logic             r_awvalid;
    logic [ADRW-1:0]  r_awaddr;
    logic [7:0]       r_awlen;
    logic [2:0]       r_awsize;
    logic             r_err_4k;

    logic [OCW-1:0]   outs_cnt;

    logic [7:0]       lq_mem [MAX_OUTS];
    logic [PW-1:0]    lq_wp;
    logic [PW-1:0]    lq_rp;
    logic [OCW-1:0]   lq_cnt;
    logic             lq_pop;

    logic [7:0]       cur_len;
    logic [7:0]       beat_cnt;
    logic             w_load;

    logic [DATW-1:0]  r_wdata;
    logic [STBW-1:0]  r_wstrb;
    logic             r_wvalid;
    logic             r_wlast;

    logic             r_rsp_valid;
    logic [1:0]       r_rsp_resp;

    logic             unused_bid;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTS - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Command side
    // ------------------------------------------------------------------
    assign req_ready = ~r_awvalid & (outs_cnt < OCW'(MAX_OUTS));
    assign accept    = req_valid & req_ready;
    assign b_hs      = i_m_bvalid & o_m_bready;

    always_comb begin
        req_size_c = (req_size > SZ_MAX) ? SZ_MAX : req_size;
        // End offset of the burst within its 4KB page, using the size that
        // is actually issued on AW.
        span_end   = 17'(req_addr[11:0]) + ((17'(req_len) + 17'd1) << req_size_c);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_awvalid <= 1'b0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_err_4k  <= 1'b0;
        end else begin
            r_err_4k <= accept & (span_end > 17'd4096);
            if (accept) begin
                r_awvalid <= 1'b1;
                r_awaddr  <= req_addr;
                r_awlen   <= req_len;
                r_awsize  <= req_size_c;
            end else if (i_m_awready) begin
                r_awvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            outs_cnt <= '0;
        end else begin
            case ({accept, b_hs})
                2'b10:   outs_cnt <= outs_cnt + OCW'(1);
                2'b01:   outs_cnt <= outs_cnt - OCW'(1);
                default: outs_cnt <= outs_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Burst length queue: one entry per accepted command. Its occupancy
    // never exceeds outs_cnt, so it cannot overflow.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < MAX_OUTS; i++) begin
                lq_mem[i] <= '0;
            end
            lq_wp  <= '0;
            lq_rp  <= '0;
            lq_cnt <= '0;
        end else begin
            if (accept) begin
                lq_mem[lq_wp] <= req_len;
                lq_wp         <= ptr_inc(lq_wp);
            end
            if (lq_pop) begin
                lq_rp <= ptr_inc(lq_rp);
            end
            case ({accept, lq_pop})
                2'b10:   lq_cnt <= lq_cnt + OCW'(1);
                2'b01:   lq_cnt <= lq_cnt - OCW'(1);
                default: lq_cnt <= lq_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // W channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        lq_pop      = 1'b0;
        dat_ready   = 1'b0;
        w_load      = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (lq_cnt != '0) begin
                    lq_pop      = 1'b1;
                    w_state_nxt = W_BURST;
                end
            end
            W_BURST: begin
                // The single output register can take a beat when it is
                // empty or being drained this cycle.
                dat_ready = ~r_wvalid | i_m_wready;
                w_load    = dat_valid & dat_ready;
                if (w_load && (beat_cnt == cur_len)) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: begin
                w_state_nxt = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cur_len  <= '0;
            beat_cnt <= '0;
        end else if (lq_pop) begin
            cur_len  <= lq_mem[lq_rp];
            beat_cnt <= '0;
        end else if (w_load) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
        end else if (w_load) begin
            r_wdata  <= dat_data;
            r_wstrb  <= dat_strb;
            r_wvalid <= 1'b1;
            r_wlast  <= (beat_cnt == cur_len);
        end else if (i_m_wready) begin
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // B channel / response port
    // ------------------------------------------------------------------
    assign o_m_bready = ~r_rsp_valid | rsp_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_resp  <= '0;
        end else if (b_hs) begin
            r_rsp_valid <= 1'b1;
            r_rsp_resp  <= i_m_bresp;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign unused_bid = ^i_m_bid;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_m_awid     = TAGW'(AWID);
    assign o_m_awaddr   = r_awaddr;
    assign o_m_awlen    = r_awlen;
    assign o_m_awsize   = r_awsize;
    assign o_m_awburst  = 2'b01;
    assign o_m_awlock   = 1'b0;
    assign o_m_awcache  = 4'b0011;
    assign o_m_awprot   = 3'b000;
    assign o_m_awregion = 4'b0000;
    assign o_m_awvalid  = r_awvalid;

    assign o_m_wdata    = r_wdata;
    assign o_m_wstrb    = r_wstrb;
    assign o_m_wlast    = r_wlast;
    assign o_m_wvalid   = r_wvalid;

    assign rsp_valid    = r_rsp_valid;
    assign rsp_resp     = r_rsp_resp;
    assign err_4k       = r_err_4k;

endmodule

// File: tb/tb_axi4_m_wburst.sv
module tb_axi4_m_wburst;
    localparam int unsigned TAGW  = 3;
    localparam int unsigned ADRW  = 32;
    localparam int unsigned DATW  = 256;
    localparam int unsigned STBW  = DATW / 8;
    localparam int unsigned MAXO  = 4;
    localparam int unsigned SZMAX = 5;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [ADRW-1:0] req_addr;
    logic [7:0]      req_len;
    logic [2:0]      req_size;
    logic            req_valid;
    logic            req_ready;
    logic [DATW-1:0] dat_data;
    logic [STBW-1:0] dat_strb;
    logic            dat_valid;
    logic            dat_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_resp;
    logic            rsp_ready;
    logic            err_4k;
    logic [TAGW-1:0] o_m_awid;
    logic [ADRW-1:0] o_m_awaddr;
    logic [7:0]      o_m_awlen;
    logic [2:0]      o_m_awsize;
    logic [1:0]      o_m_awburst;
    logic            o_m_awlock;
    logic [3:0]      o_m_awcache;
    logic [2:0]      o_m_awprot;
    logic [3:0]      o_m_awregion;
    logic            o_m_awvalid;
    logic            i_m_awready;
    logic [DATW-1:0] o_m_wdata;
    logic [STBW-1:0] o_m_wstrb;
    logic            o_m_wlast;
    logic            o_m_wvalid;
    logic            i_m_wready;
    logic [TAGW-1:0] i_m_bid;
    logic [1:0]      i_m_bresp;
    logic            i_m_bvalid;
    logic            o_m_bready;

    always #5 i_clk = ~i_clk;

    axi4_m_wburst #(
        .TAGW(TAGW), .ADRW(ADRW), .DATW(DATW), .STBW(STBW),
        .MAX_OUTS(MAXO), .AWID(0)
    ) u_dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
        .req_valid(req_valid), .req_ready(req_ready),
        .dat_data(dat_data), .dat_strb(dat_strb),
        .dat_valid(dat_valid), .dat_ready(dat_ready),
        .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_ready(rsp_ready),
        .err_4k(err_4k),
        .o_m_awid(o_m_awid), .o_m_awaddr(o_m_awaddr), .o_m_awlen(o_m_awlen),
        .o_m_awsize(o_m_awsize), .o_m_awburst(o_m_awburst), .o_m_awlock(o_m_awlock),
        .o_m_awcache(o_m_awcache), .o_m_awprot(o_m_awprot), .o_m_awregion(o_m_awregion),
        .o_m_awvalid(o_m_awvalid), .i_m_awready(i_m_awready),
        .o_m_wdata(o_m_wdata), .o_m_wstrb(o_m_wstrb), .o_m_wlast(o_m_wlast),
        .o_m_wvalid(o_m_wvalid), .i_m_wready(i_m_wready),
        .i_m_bid(i_m_bid), .i_m_bresp(i_m_bresp), .i_m_bvalid(i_m_bvalid),
        .o_m_bready(o_m_bready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } cmd_t;

    typedef struct {
        logic [DATW-1:0] d;
        logic [STBW-1:0] s;
        logic            last;
    } beat_t;

    // Reference model: commands waiting to be offered, commands accepted but
    // not yet on AW, beats waiting to be offered, beats held by the master,
    // and responses held on the response port.
    cmd_t        cmd_q[$];
    cmd_t        aw_q[$];
    beat_t       src_q[$];
    beat_t       w_q[$];
    logic [1:0]  rsp_q[$];

    int unsigned outs, aw_done, wl_done, b_sent, beats_owed;
    logic        exp_err;
    bit          acc_l, dhs_l, bhs_l;
    bit          b_en;
    int unsigned p_req, p_dat, p_awr, p_wr, p_b, p_rsp;
    int unsigned cyc, w_cnt, err_seen, first_w_cyc, last_w_cyc;
    int unsigned n_chk, n_err;

    task automatic chk(input string tag, input logic [DATW-1:0] got, input logic [DATW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit rnd(input int unsigned pct);
        return $urandom_range(99) < pct;
    endfunction

    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        return (int'(s) > SZMAX) ? 3'(SZMAX) : s;
    endfunction

    // Bytes covered by the burst, added to its offset in the 4KB page.
    function automatic logic crosses_4k(input cmd_t c);
        int unsigned bytes;
        int unsigned off;
        bytes = (int'(c.len) + 1) * (1 << int'(clamp_size(c.size)));
        off   = c.addr % 4096;
        return (off + bytes) > 4096;
    endfunction

    task automatic set_prob(input int unsigned pr, input int unsigned pd, input int unsigned pa,
                            input int unsigned pw, input int unsigned pb, input int unsigned ps);
        p_req = pr; p_dat = pd; p_awr = pa; p_wr = pw; p_b = pb; p_rsp = ps;
    endtask

    task automatic mdl_clear();
        cmd_q.delete(); aw_q.delete(); src_q.delete(); w_q.delete(); rsp_q.delete();
        outs = 0; aw_done = 0; wl_done = 0; b_sent = 0; beats_owed = 0;
        exp_err = 1'b0; acc_l = 0; dhs_l = 0; bhs_l = 0;
        req_valid = 1'b0; req_addr = '0; req_len = '0; req_size = '0;
        dat_valid = 1'b0; dat_data = '0; dat_strb = '0;
        i_m_bvalid = 1'b0; i_m_bresp = '0; i_m_bid = '0;
        i_m_awready = 1'b0; i_m_wready = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic add_cmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
        cmd_t  c;
        beat_t b;
        c.addr = a; c.len = l; c.size = s;
        cmd_q.push_back(c);
        for (int i = 0; i <= int'(l); i++) begin
            for (int k = 0; k < int'(DATW / 32); k++) b.d[k*32 +: 32] = $urandom();
            b.s    = STBW'($urandom());
            b.last = (i == int'(l));
            src_q.push_back(b);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then check the
    // DUT against the model and advance the model by the handshakes that
    // the next rising edge will complete.
    task automatic tick();
        bit          acc, awhs, whs, dhs, bhs, rhs;
        cmd_t        c;
        beat_t       b;
        int unsigned done;
        @(negedge i_clk);
        cyc++;
        if (!(req_valid && !acc_l)) begin
            req_valid = 1'b0;
            if (cmd_q.size() != 0 && rnd(p_req)) begin
                req_valid = 1'b1;
                req_addr  = cmd_q[0].addr;
                req_len   = cmd_q[0].len;
                req_size  = cmd_q[0].size;
            end
        end
        if (!(dat_valid && !dhs_l)) begin
            dat_valid = 1'b0;
            if (src_q.size() != 0 && rnd(p_dat)) begin
                dat_valid = 1'b1;
                dat_data  = src_q[0].d;
                dat_strb  = src_q[0].s;
            end
        end
        if (!(i_m_bvalid && !bhs_l)) begin
            i_m_bvalid = 1'b0;
            done = (aw_done < wl_done) ? aw_done : wl_done;
            if (b_en && done > b_sent && rnd(p_b)) begin
                i_m_bvalid = 1'b1;
                i_m_bresp  = 2'($urandom());
                i_m_bid    = TAGW'($urandom());
            end
        end
        i_m_awready = rnd(p_awr);
        i_m_wready  = rnd(p_wr);
        rsp_ready   = rnd(p_rsp);
        #1;
        chk("awvalid", o_m_awvalid, aw_q.size() != 0);
        if (aw_q.size() != 0) begin
            chk("awaddr", o_m_awaddr, aw_q[0].addr);
            chk("awlen", o_m_awlen, aw_q[0].len);
            chk("awsize", o_m_awsize, aw_q[0].size);
        end
        chk("wvalid", o_m_wvalid, w_q.size() != 0);
        chk("rsp_valid", rsp_valid, rsp_q.size() != 0);
        if (rsp_q.size() != 0) chk("rsp_resp", rsp_resp, rsp_q[0]);
        chk("err_4k", err_4k, exp_err);
        chk("req_ready", req_ready, (aw_q.size() == 0) && (outs < MAXO));
        chk("bready", o_m_bready, (rsp_q.size() == 0) || rsp_ready);
        if (beats_owed == 0) chk("dat_ready_idle", dat_ready, 1'b0);
        chk("dat_ready_bp", dat_ready & o_m_wvalid & ~i_m_wready, 1'b0);
        if (err_4k) err_seen++;

        acc  = req_valid & req_ready;
        awhs = o_m_awvalid & i_m_awready;
        whs  = o_m_wvalid & i_m_wready;
        dhs  = dat_valid & dat_ready;
        bhs  = i_m_bvalid & o_m_bready;
        rhs  = rsp_valid & rsp_ready;

        exp_err = 1'b0;
        if (awhs && aw_q.size() != 0) begin
            void'(aw_q.pop_front());
            aw_done++;
        end
        if (acc) begin
            c = cmd_q.pop_front();
            exp_err = crosses_4k(c);
            c.size = clamp_size(c.size);
            aw_q.push_back(c);
            outs++;
            beats_owed += int'(c.len) + 1;
        end
        if (whs) begin
            if (w_q.size() == 0) begin
                chk("w_spurious", 1'b1, 1'b0);
            end else begin
                b = w_q.pop_front();
                chk("wdata", o_m_wdata, b.d);
                chk("wstrb", o_m_wstrb, b.s);
                chk("wlast", o_m_wlast, b.last);
                if (b.last) wl_done++;
            end
            if (w_cnt == 0) first_w_cyc = cyc;
            last_w_cyc = cyc;
            w_cnt++;
        end
        if (dhs && src_q.size() != 0) begin
            w_q.push_back(src_q.pop_front());
            if (beats_owed != 0) beats_owed--;
        end
        if (rhs && rsp_q.size() != 0) void'(rsp_q.pop_front());
        if (bhs) begin
            rsp_q.push_back(i_m_bresp);
            if (outs != 0) outs--;
            b_sent++;
        end
        acc_l = acc; dhs_l = dhs; bhs_l = bhs;
    endtask

    task automatic run_idle(input int unsigned limit);
        int unsigned n;
        bit          idle;
        n = 0;
        idle = 0;
        while (n < limit && !idle) begin
            tick();
            n++;
            idle = (cmd_q.size() == 0) && (aw_q.size() == 0) && (src_q.size() == 0) &&
                   (w_q.size() == 0) && (rsp_q.size() == 0) && (outs == 0);
        end
        chk("run_idle", idle, 1'b1);
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; w_cnt = 0; err_seen = 0;
        first_w_cyc = 0; last_w_cyc = 0; b_en = 1;
        i_rst = 1'b1;
        mdl_clear();
        set_prob(100, 100, 100, 100, 100, 100);

        // Reset state
        repeat (2) @(negedge i_clk);
        #1;
        chk("rst_awvalid", o_m_awvalid, 1'b0);
        chk("rst_wvalid", o_m_wvalid, 1'b0);
        chk("rst_wlast", o_m_wlast, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_err_4k", err_4k, 1'b0);
        chk("rst_dat_ready", dat_ready, 1'b0);
        chk("rst_awaddr", o_m_awaddr, '0);
        chk("rst_awlen", o_m_awlen, '0);
        chk("rst_awsize", o_m_awsize, '0);
        chk("rst_wdata", o_m_wdata, '0);
        chk("rst_wstrb", o_m_wstrb, '0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("rel_req_ready", req_ready, 1'b1);
        chk("rel_bready", o_m_bready, 1'b1);
        chk("awid", o_m_awid, '0);
        chk("awburst", o_m_awburst, 2'b01);
        chk("awlock", o_m_awlock, 1'b0);
        chk("awcache", o_m_awcache, 4'b0011);
        chk("awprot", o_m_awprot, 3'b000);
        chk("awregion", o_m_awregion, 4'b0000);

        // Single beat, ready tied high
        add_cmd(32'h0000_1000, 8'd0, 3'd5);
        w_cnt = 0;
        run_idle(50);
        chk("single_beats", w_cnt, 1);

        // 16-beat burst with W ready toggling
        set_prob(100, 100, 100, 50, 100, 100);
        add_cmd(32'h0000_2000, 8'd15, 3'd5);
        w_cnt = 0;
        run_idle(200);
        chk("burst16_beats", w_cnt, 16);

        // Outstanding limit: B withheld, then released with response backpressure
        set_prob(100, 100, 100, 100, 100, 0);
        b_en = 0;
        for (int i = 0; i < 5; i++) add_cmd(32'h0000_4000 + 32'(i * 64), 8'd0, 3'd5);
        repeat (30) tick();
        chk("outs_cap_req_ready", req_ready, 1'b0);
        chk("outs_cap_pending", cmd_q.size(), 1);
        b_en = 1;
        repeat (10) tick();
        set_prob(100, 100, 100, 100, 100, 100);
        run_idle(200);

        // 4KB crossing flag, then a full 256-beat burst at one beat per cycle
        err_seen = 0;
        add_cmd(32'h0000_0FE0, 8'd1, 3'd5);
        run_idle(50);
        chk("err_4k_pulses", err_seen, 1);
        err_seen = 0;
        add_cmd(32'h0000_0040, 8'd0, 3'd3);
        run_idle(50);
        chk("no_err_4k", err_seen, 0);
        w_cnt = 0;
        add_cmd(32'h0001_0000, 8'd255, 3'd5);
        run_idle(600);
        chk("burst256_beats", w_cnt, 256);
        chk("burst256_rate", last_w_cyc - first_w_cyc, 255);

        // Oversized size is clamped to the bus width
        add_cmd(32'h0000_5000, 8'd0, 3'd7);
        run_idle(50);

        // Reset in the middle of a burst
        add_cmd(32'h0000_3000, 8'd20, 3'd5);
        w_cnt = 0;
        for (int n = 0; n < 100 && w_cnt < 7; n++) tick();
        chk("mid_beats_before_rst", w_cnt, 7);
        #1 i_rst = 1'b1;
        #1;
        chk("mid_rst_awvalid", o_m_awvalid, 1'b0);
        chk("mid_rst_wvalid", o_m_wvalid, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_dat_ready", dat_ready, 1'b0);
        chk("mid_rst_req_ready", req_ready, 1'b1);
        mdl_clear();
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        w_cnt = 0;
        add_cmd(32'h0000_6000, 8'd3, 3'd4);
        run_idle(100);
        chk("post_rst_beats", w_cnt, 4);

        // Randomized traffic
        set_prob(70, 60, 50, 60, 40, 50);
        for (int i = 0; i < 40; i++) begin
            add_cmd($urandom(), 8'($urandom_range(15)), 3'($urandom_range(SZMAX)));
        end
        run_idle(20000);
        set_prob(90, 90, 90, 90, 90, 90);
        for (int i = 0; i < 20; i++) begin
            add_cmd($urandom(), 8'($urandom_range(7)), 3'($urandom_range(SZMAX)));
        end
        run_idle(10000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
